// File: rtl/prog_fir_pkg.sv
// prog_fir_pkg: shared types and defaults for the prog_fir coefficient loader.
//   state_t     loader FSM state (IDLE, ISSUE, DRAIN, SWAP)
//   *_DEF       default widths / sizes used by prog_fir_coeff_loader
//   chan_base   base word address of a channel's coefficient region
package prog_fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam int unsigned ADDR_W_DEF     = 10;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned CHAN_W_DEF     = 6;
    localparam int unsigned STRIDE_LG2_DEF = 4;
    localparam int unsigned N_WORDS_DEF    = 10;
    localparam int unsigned RD_LAT_DEF     = 3;

    // Channel base address = {chan, stride_lg2 zero bits}; caller narrows to ADDR_W.
    function automatic logic [31:0] chan_base(input logic [31:0] chan,
                                              input int unsigned stride_lg2);
        return chan << stride_lg2;
    endfunction

endpackage

// File: rtl/prog_fir_rdlat_pipe.sv
// prog_fir_rdlat_pipe: DEPTH-deep delay line carrying a read-valid bit and the
// word index that goes with it, so both line up with RAM read data.
//   clk, rst   clock, asynchronous active-high reset (flushes the line)
//   in_valid   read issued this cycle
//   in_idx     word index of that read
//   out_valid  delayed in_valid (DEPTH cycles)
//   out_idx    delayed in_idx (DEPTH cycles)
module prog_fir_rdlat_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/prog_fir_coeff_loader.sv
// prog_fir_coeff_loader: reads one channel's coefficient words from port A of the
// coefficient RAM in a burst, writes them into the FIR shadow bank and pulses a
// swap to make them live. Sole owner of port A reads.
//   clk, rst                 clock, asynchronous active-high reset
//   load_req, load_chan      single-cycle load request and channel to load
//   load_busy, load_done     busy from first issue through done; done pulse
//   bram_en_a, bram_we,      port A enable, write enable (always 0),
//   bram_addr, bram_rd_data  word address, read data
//   coeff_wr_en/idx/data     shadow bank write strobe, word index, packed pair
//   coeff_swap               shadow -> live bank pulse (with load_done)
//   load_sum                 wrapping sum of the last completed load's words
// Optional feature: define PROG_FIR_COEFF_CHECKSUM_EN to build the load_sum
// accumulator; otherwise load_sum is tied to 0.
module prog_fir_coeff_loader
    import prog_fir_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CHAN_W     = CHAN_W_DEF,
    parameter int unsigned STRIDE_LG2 = STRIDE_LG2_DEF,
    parameter int unsigned N_WORDS    = N_WORDS_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [CHAN_W-1:0]     load_chan,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  bram_en_a,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    input  logic [DATA_W-1:0]     bram_rd_data,
    output logic                  coeff_wr_en,
    output logic [STRIDE_LG2-1:0] coeff_wr_idx,
    output logic [DATA_W-1:0]     coeff_wr_data,
    output logic                  coeff_swap,
    output logic [DATA_W-1:0]     load_sum
);

    state_t                state, state_next;
    logic [STRIDE_LG2-1:0] cnt, cnt_next;
    logic                  pend, pend_next;
    logic [CHAN_W-1:0]     pend_chan, pend_chan_next, start_chan;
    logic                  start, last_issue, last_wr;
    logic                  pipe_valid;
    logic [STRIDE_LG2-1:0] pipe_idx;

    logic                  en_next, busy_next, swap_next, wr_en_next;
    logic [ADDR_W-1:0]     addr_next;
    logic [STRIDE_LG2-1:0] wr_idx_next;
    logic [DATA_W-1:0]     wr_data_next;

    assign bram_we    = 1'b0;
    assign last_issue = (state == ISSUE) && (cnt == STRIDE_LG2'(N_WORDS - 1));
    assign last_wr    = coeff_wr_en && (coeff_wr_idx == STRIDE_LG2'(N_WORDS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; SWAP goes straight back to ISSUE when work is waiting.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_req || pend) state_next = ISSUE;
            ISSUE:   if (last_issue)       state_next = DRAIN;
            DRAIN:   if (last_wr)          state_next = SWAP;
            SWAP:    state_next = (load_req || pend) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values. A fresh request beats the pending one.
    always_comb begin
        start          = (state_next == ISSUE) && (state != ISSUE);
        start_chan     = load_req ? load_chan : pend_chan;

        en_next        = (state_next == ISSUE);
        busy_next      = (state_next != IDLE);
        swap_next      = (state_next == SWAP);
        addr_next      = bram_addr;
        cnt_next       = cnt;
        pend_next      = pend;
        pend_chan_next = pend_chan;

        if (start) begin
            addr_next = ADDR_W'(chan_base(32'(start_chan), STRIDE_LG2));
            cnt_next  = '0;
        end else if (state == ISSUE && state_next == ISSUE) begin
            addr_next = bram_addr + ADDR_W'(1);
            cnt_next  = cnt + STRIDE_LG2'(1);
        end

        // One-deep pending slot, latest request wins.
        if (start) begin
            pend_next = 1'b0;
        end else if (load_req && state != IDLE) begin
            pend_next      = 1'b1;
            pend_chan_next = load_chan;
        end

        wr_en_next   = pipe_valid;
        wr_idx_next  = pipe_valid ? pipe_idx : coeff_wr_idx;
        wr_data_next = pipe_valid ? bram_rd_data : coeff_wr_data;
    end

    // Registered outputs and control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_busy     <= 1'b0;
            load_done     <= 1'b0;
            coeff_swap    <= 1'b0;
            bram_en_a     <= 1'b0;
            bram_addr     <= '0;
            cnt           <= '0;
            pend          <= 1'b0;
            pend_chan     <= '0;
            coeff_wr_en   <= 1'b0;
            coeff_wr_idx  <= '0;
            coeff_wr_data <= '0;
        end else begin
            load_busy     <= busy_next;
            load_done     <= swap_next;
            coeff_swap    <= swap_next;
            bram_en_a     <= en_next;
            bram_addr     <= addr_next;
            cnt           <= cnt_next;
            pend          <= pend_next;
            pend_chan     <= pend_chan_next;
            coeff_wr_en   <= wr_en_next;
            coeff_wr_idx  <= wr_idx_next;
            coeff_wr_data <= wr_data_next;
        end
    end

    // Valid/index travel alongside the read so data and index meet at the write stage.
    prog_fir_rdlat_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (STRIDE_LG2)
    ) u_rdlat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bram_en_a),
        .in_idx    (cnt),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

`ifdef PROG_FIR_COEFF_CHECKSUM_EN
    logic [DATA_W-1:0] acc, acc_add, acc_next, sum_next;

    // Accumulate written words; publish the total on SWAP entry so it is valid with load_done.
    always_comb begin
        acc_add  = acc + (coeff_wr_en ? coeff_wr_data : '0);
        acc_next = start ? '0 : acc_add;
        sum_next = (state_next == SWAP) ? acc_add : load_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            load_sum <= '0;
        end else begin
            acc      <= acc_next;
            load_sum <= sum_next;
        end
    end
`else
    assign load_sum = '0;
`endif

endmodule

// File: tb/tb_prog_fir_coeff_loader.sv
// tb_prog_fir_coeff_loader: drives two loader instances (default RD_LAT=3/N_WORDS=10
// and RD_LAT=1/N_WORDS=16) with the same directed requests; a cycle-level
// behavioural model predicts every output and a negedge process compares them.
module tb_prog_fir_coeff_loader;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic [5:0] load_chan;

    logic [1:0]        busy, done, en, we, wr_en, swap;
    logic [1:0][9:0]   addr;
    logic [1:0][3:0]   wr_idx;
    logic [1:0][31:0]  wr_data, sum, rd;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int swaps [2] = '{0, 0};

    localparam int NW [2] = '{10, 16};
    localparam int LT [2] = '{3, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_fir_coeff_loader dut0 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_chan(load_chan),
        .load_busy(busy[0]), .load_done(done[0]), .bram_en_a(en[0]), .bram_we(we[0]),
        .bram_addr(addr[0]), .bram_rd_data(rd[0]), .coeff_wr_en(wr_en[0]),
        .coeff_wr_idx(wr_idx[0]), .coeff_wr_data(wr_data[0]), .coeff_swap(swap[0]),
        .load_sum(sum[0])
    );

    prog_fir_coeff_loader #(.N_WORDS(16), .RD_LAT(1)) dut5 (
        .clk(clk), .rst(rst), .load_req(load_req), .load_chan(load_chan),
        .load_busy(busy[1]), .load_done(done[1]), .bram_en_a(en[1]), .bram_we(we[1]),
        .bram_addr(addr[1]), .bram_rd_data(rd[1]), .coeff_wr_en(wr_en[1]),
        .coeff_wr_idx(wr_idx[1]), .coeff_wr_data(wr_data[1]), .coeff_swap(swap[1]),
        .load_sum(sum[1])
    );

    // RAM models: word at a holds a + 0x1000, returned RD_LAT cycles after issue.
    logic [31:0] r0 [3];
    always @(posedge clk) begin
        r0[0] <= en[0] ? 32'(addr[0]) + 32'h1000 : 32'hDEAD0000;
        r0[1] <= r0[0];
        r0[2] <= r0[1];
        rd[1] <= en[1] ? 32'(addr[1]) + 32'h1000 : 32'hDEAD0000;
    end
    assign rd[0] = r0[2];

    // ---------------- behavioural model ----------------
    int m_act [2], m_s [2], m_ch [2], m_pend [2], m_pch [2];
    int e_en [2], e_addr [2], e_wr [2], e_idx [2], e_data [2], e_done [2], e_busy [2];
    logic [31:0] e_sum [2];

    function automatic logic [31:0] ch_sum(input int ch, input int n);
        logic [31:0] s = 0;
        for (int j = 0; j < n; j++) s += 32'(ch * 16 + j + 32'h1000);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_pch[i] = 0; m_s[i] = 0; m_ch[i] = 0;
            e_en[i] = 0; e_addr[i] = 0; e_wr[i] = 0; e_idx[i] = 0; e_data[i] = 0;
            e_done[i] = 0; e_busy[i] = 0; e_sum[i] = 0;
        end
    endtask

    // Advance instance i from cycle c (inputs of cycle c) to cycle c+1.
    task automatic model_step(input int i, input int c);
        int n = NW[i];
        int l = LT[i];
        int d = m_s[i] + n + l + 1;
        int k, j;
        if (m_act[i] == 0) begin
            if (load_req) begin m_act[i] = 1; m_s[i] = c + 1; m_ch[i] = int'(load_chan); end
        end else if (c == d) begin
`ifdef PROG_FIR_COEFF_CHECKSUM_EN
            e_sum[i] = ch_sum(m_ch[i], n);
`endif
            if (load_req) begin
                m_s[i] = c + 1; m_ch[i] = int'(load_chan); m_pend[i] = 0;
            end else if (m_pend[i] != 0) begin
                m_s[i] = c + 1; m_ch[i] = m_pch[i]; m_pend[i] = 0;
            end else begin
                m_act[i] = 0;
            end
        end else if (load_req) begin
            m_pend[i] = 1; m_pch[i] = int'(load_chan);
        end
        k = c + 1 - m_s[i];
        j = k - l - 1;
        e_busy[i] = m_act[i];
        e_en[i]   = (m_act[i] != 0 && k < n) ? 1 : 0;
        if (e_en[i] != 0) e_addr[i] = m_ch[i] * 16 + k;
        e_wr[i]   = (m_act[i] != 0 && j >= 0 && j < n) ? 1 : 0;
        e_idx[i]  = j;
        e_data[i] = m_ch[i] * 16 + j + 32'h1000;
        e_done[i] = (m_act[i] != 0 && k == n + l + 1) ? 1 : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i, cyc);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got 0x%0h want 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("load_busy", i, 32'(busy[i]), 32'(e_busy[i]));
            chk("bram_en_a", i, 32'(en[i]), 32'(e_en[i]));
            chk("bram_we",   i, 32'(we[i]), 32'd0);
            chk("bram_addr", i, 32'(addr[i]), 32'(e_addr[i]));
            chk("coeff_wr_en", i, 32'(wr_en[i]), 32'(e_wr[i]));
            if (e_wr[i] != 0) begin
                chk("coeff_wr_idx",  i, 32'(wr_idx[i]), 32'(e_idx[i]));
                chk("coeff_wr_data", i, wr_data[i], 32'(e_data[i]));
            end
            chk("coeff_swap", i, 32'(swap[i]), 32'(e_done[i]));
            chk("load_done",  i, 32'(done[i]), 32'(e_done[i]));
            if (e_done[i] == 0) chk("load_sum", i, sum[i], e_sum[i]);
            if (swap[i]) swaps[i]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go_to(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic req_at(input int t, input logic [5:0] ch);
        go_to(t);
        load_req = 1'b1; load_chan = ch;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int i, input int t0, input int exp_cyc);
        while (!done[i] && cyc < t0 + 80) begin @(posedge clk); #1; end
        chk("done_cycle", i, 32'(cyc - t0), 32'(exp_cyc));
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy != 2'b00 && b < 120) begin @(posedge clk); #1; b++; end
        chk("idle_reached", 0, 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int t, sw0, sw1;
        rst = 1'b1; load_req = 1'b0; load_chan = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: chan 2 basic load
        t = cyc + 1;
        req_at(t, 6'd2);
        go_to(t + 1);  chk("t1_addr0", 0, 32'({en[0], addr[0]}), 32'h420);
        go_to(t + 5);  chk("t1_wr0", 0, {wr_en[0], wr_idx[0], wr_data[0][26:0]}, {1'b1, 4'd0, 27'h1020});
        go_to(t + 14); chk("t1_wr9", 0, {wr_en[0], wr_idx[0], wr_data[0][26:0]}, {1'b1, 4'd9, 27'h1029});
        wait_done(0, t, 15);
        wait_idle();

        // 2: pending overwrite, latest wins
        t = cyc + 1;
        req_at(t, 6'd5);
        req_at(t + 6, 6'd7);
        req_at(t + 8, 6'd9);
        go_to(t + 15); chk("t2_done", 0, 32'(done[0]), 32'd1);
        go_to(t + 16); chk("t2_ch9_issue", 0, 32'({en[0], addr[0]}), 32'h490);
        wait_idle();

        // 3: reset mid-load aborts without swap
        t = cyc + 1;
        sw0 = swaps[0];
        req_at(t, 6'd4);
        go_to(t + 7);
        rst = 1'b1;
        @(negedge clk);
        chk("t3_rst_out", 0, 32'({busy[0], en[0], addr[0], wr_en[0]}), 32'd0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;
        chk("t3_no_swap", 0, 32'(swaps[0] - sw0), 32'd0);
        t = cyc + 1;
        req_at(t, 6'd6);
        wait_done(0, t, 15);
        wait_idle();

        // 4: request in the SWAP cycle, back-to-back loads
        t = cyc + 1;
        sw0 = swaps[0]; sw1 = swaps[1];
        req_at(t, 6'd1);
        req_at(t + 15, 6'd3);
        chk("t4_b2b_issue", 0, 32'({busy[0], en[0], addr[0]}), 32'hC30);
        wait_idle();
        chk("t4_swaps", 0, 32'(swaps[0] - sw0), 32'd2);
        chk("t4_swaps", 1, 32'(swaps[1] - sw1), 32'd2);

        // 5: top channel, no wrap; RD_LAT=1 instance done at 19
        t = cyc + 1;
        req_at(t, 6'd63);
        wait_done(1, t, 19);
        wait_idle();
        chk("t5_last_addr", 1, 32'(addr[1]), 32'd1023);
        chk("t5_last_addr", 0, 32'(addr[0]), 32'd1017);

        // 6: checksum of chan 0
        t = cyc + 1;
        req_at(t, 6'd0);
        wait_idle();
`ifdef PROG_FIR_COEFF_CHECKSUM_EN
        chk("t6_sum", 0, sum[0], 32'h0000A02D);
        chk("t6_sum", 1, sum[1], 32'h00010078);
`else
        chk("t6_sum", 0, sum[0], 32'h0);
        chk("t6_sum", 1, sum[1], 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
